pc_sequencer: RTL and testbench

- Fetch-stage controller: owns the program counter and sequences the 32-bit PC incrementer, which computes pc+1 as a word address.
- Issues one instruction-memory request at a time and presents fetched instructions to decode.
- Applies redirects (branch/jump), exceptions and pipeline stalls with fixed priority.
- Sits between the instruction memory port and the IF/ID boundary.

---
 rtl/pc_sequencer.sv | 167 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch-stage controller: owns the word-addressed PC, issues one instruction-memory
// request at a time and presents fetched instructions to decode.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        exc_req,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_next,
    output logic [31:0] exc_epc
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_kill;
    logic        r_imem_req;
    logic [31:0] r_imem_addr;
    logic        r_if_valid;
    logic [31:0] r_if_instr;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_pc_next;
    logic [31:0] r_exc_epc;

    logic [31:0] w_pc_inc;
    logic        w_flush;
    logic [31:0] w_flush_target;
    logic [31:0] w_epc;
    logic        w_ack;

    // Incrementer: carry-in tied low, carry-out dropped so 0xFFFF_FFFF wraps to 0.
    function automatic logic [31:0] pc_incr(input logic [31:0] a);
        return a + 32'd1;
    endfunction

    assign w_pc_inc       = pc_incr(r_pc);
    assign w_flush        = exc_req | redirect_valid;
    assign w_flush_target = exc_req ? EXC_VECTOR : redirect_pc;
    assign w_epc          = r_if_valid ? r_if_pc : r_pc;
    assign w_ack          = imem_ack && ((r_state == S_REQ) || (r_state == S_WAIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_kill       <= 1'b0;
            r_imem_req   <= 1'b0;
            r_imem_addr  <= RESET_PC;
            r_if_valid   <= 1'b0;
            r_if_instr   <= 32'd0;
            r_if_pc      <= 32'd0;
            r_if_pc_next <= 32'd0;
            r_exc_epc    <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state     <= S_REQ;
                    r_imem_req  <= 1'b1;
                    r_imem_addr <= r_pc;
                end

                S_REQ, S_WAIT: begin
                    if (w_flush) begin
                        r_pc       <= w_flush_target;
                        r_if_valid <= 1'b0;
                        if (exc_req) begin
                            r_exc_epc <= w_epc;
                        end
                        if (w_ack) begin
                            // The completing fetch belongs to the old path; drop it.
                            r_kill      <= 1'b0;
                            r_state     <= S_REQ;
                            r_imem_req  <= 1'b1;
                            r_imem_addr <= w_flush_target;
                        end else begin
                            // Request stays on the bus with its old address until acked.
                            r_kill  <= 1'b1;
                            r_state <= S_WAIT;
                        end
                    end else if (w_ack) begin
                        if (r_kill) begin
                            r_kill      <= 1'b0;
                            r_if_valid  <= 1'b0;
                            r_state     <= S_REQ;
                            r_imem_req  <= 1'b1;
                            r_imem_addr <= r_pc;
                        end else begin
                            r_if_instr   <= imem_rdata;
                            r_if_pc      <= r_pc;
                            r_if_pc_next <= w_pc_inc;
                            r_if_valid   <= 1'b1;
                            r_pc         <= w_pc_inc;
                            if (stall) begin
                                r_state    <= S_HOLD;
                                r_imem_req <= 1'b0;
                            end else begin
                                r_state     <= S_REQ;
                                r_imem_req  <= 1'b1;
                                r_imem_addr <= w_pc_inc;
                            end
                        end
                    end else begin
                        r_state    <= S_WAIT;
                        r_if_valid <= 1'b0;
                    end
                end

                S_HOLD: begin
                    if (w_flush) begin
                        r_pc        <= w_flush_target;
                        r_if_valid  <= 1'b0;
                        r_state     <= S_REQ;
                        r_imem_req  <= 1'b1;
                        r_imem_addr <= w_flush_target;
                        if (exc_req) begin
                            r_exc_epc <= w_epc;
                        end
                    end else if (!stall) begin
                        r_if_valid  <= 1'b0;
                        r_state     <= S_REQ;
                        r_imem_req  <= 1'b1;
                        r_imem_addr <= r_pc;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign imem_req   = r_imem_req;
    assign imem_addr  = r_imem_addr;
    assign if_valid   = r_if_valid;
    assign if_instr   = r_if_instr;
    assign if_pc      = r_if_pc;
    assign if_pc_next = r_if_pc_next;
    assign exc_epc    = r_exc_epc;

    a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (r_imem_req && !imem_ack) |=> (r_imem_req && $stable(r_imem_addr)));

    a_kill_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
        r_kill |-> (r_state == S_WAIT));

    a_hold_outputs: assert property (@(posedge clk) disable iff (!rst_n)
        (r_state == S_HOLD) |-> (!r_imem_req && r_if_valid));

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a scoreboard queue of expected fetches plus per-scenario tasks.
module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        rst_n_w;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        exc_req;
    logic        imem_ack;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_next;
    logic [31:0] exc_epc;

    logic        w_imem_req;
    logic [31:0] w_imem_addr;
    logic [31:0] w_imem_rdata;
    logic        w_if_valid;
    logic [31:0] w_if_instr;
    logic [31:0] w_if_pc;
    logic [31:0] w_if_pc_next;
    logic [31:0] w_exc_epc;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
    endfunction

    assign imem_rdata   = mem_word(imem_addr);
    assign w_imem_rdata = mem_word(w_imem_addr);

    pc_sequencer u_dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .exc_req(exc_req),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pc_next(if_pc_next),
        .exc_epc(exc_epc)
    );

    pc_sequencer #(.RESET_PC(32'hFFFF_FFFF), .EXC_VECTOR(32'h0000_0020)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n_w), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .exc_req(exc_req),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ack(imem_ack), .imem_rdata(w_imem_rdata),
        .if_valid(w_if_valid), .if_instr(w_if_instr), .if_pc(w_if_pc), .if_pc_next(w_if_pc_next),
        .exc_epc(w_exc_epc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance one cycle; every instruction presented must be the next one on the scoreboard.
    task automatic tick_sb();
        exp_t e;
        tick();
        if (if_valid === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected if_valid with if_pc=%h, queue empty", if_pc);
            end else begin
                e = sb_q.pop_front();
                if (if_pc !== e.pc || if_instr !== e.instr || if_pc_next !== e.pc + 32'd1) begin
                    errors++;
                    $display("FAIL sb_fetch got pc=%h instr=%h next=%h, want pc=%h instr=%h next=%h",
                             if_pc, if_instr, if_pc_next, e.pc, e.instr, e.pc + 32'd1);
                end
            end
        end
    endtask

    task automatic sb_expect(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = mem_word(pc);
        sb_q.push_back(e);
    endtask

    task automatic sb_drained(input string name);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain got %0d pending fetches, want 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    // Redirect with a concurrent ack so the sequencer lands in REQ at target.
    task automatic goto_pc(input logic [31:0] target);
        imem_ack       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        redirect_valid = 1'b0;
        imem_ack       = 1'b0;
        checks++;
        if (if_valid !== 1'b0 || imem_addr !== target || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL goto_%h got valid=%b req=%b addr=%h, want 0 1 %h",
                     target, if_valid, imem_req, imem_addr, target);
        end
    endtask

    task automatic test_reset();
        stall = 0; redirect_valid = 0; redirect_pc = 0; exc_req = 0; imem_ack = 0;
        rst_n = 0; rst_n_w = 0;
        repeat (2) tick();
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'd0) begin
            errors++; $display("FAIL reset_imem got req=%b addr=%h, want 0 0", imem_req, imem_addr);
        end
        checks++;
        if (if_valid !== 1'b0 || if_instr !== 32'd0 || if_pc !== 32'd0 || if_pc_next !== 32'd0) begin
            errors++; $display("FAIL reset_if got v=%b i=%h pc=%h nx=%h, want all 0", if_valid, if_instr, if_pc, if_pc_next);
        end
        checks++;
        if (exc_epc !== 32'd0) begin
            errors++; $display("FAIL reset_epc got %h want 0", exc_epc);
        end
        checks++;
        if (w_imem_addr !== 32'hFFFF_FFFF || w_imem_req !== 1'b0) begin
            errors++; $display("FAIL reset_wrap got req=%b addr=%h, want 0 ffffffff", w_imem_req, w_imem_addr);
        end
    endtask

    task automatic test_zero_wait();
        rst_n    = 1'b1;
        imem_ack = 1'b1;
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd0 || if_valid !== 1'b0) begin
            errors++; $display("FAIL zw_first got req=%b addr=%h v=%b, want 1 0 0", imem_req, imem_addr, if_valid);
        end
        for (int k = 0; k < 4; k++) begin
            sb_expect(k);
            tick_sb();
            checks++;
            if (imem_addr !== k + 1 || if_valid !== 1'b1) begin
                errors++; $display("FAIL zw_addr%0d got addr=%h v=%b, want %h 1", k, imem_addr, if_valid, k + 1);
            end
        end
        imem_ack = 1'b0;
        sb_drained("zero_wait");
    endtask

    task automatic test_wait_latency();
        goto_pc(32'd5);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'd5) begin
                errors++; $display("FAIL lat_hold%0d got req=%b addr=%h, want 1 5", c, imem_req, imem_addr);
            end
            if (c == 2) begin
                imem_ack = 1'b1;
                sb_expect(32'd5);
                tick_sb();
            end else begin
                tick();
                checks++;
                if (if_valid !== 1'b0) begin
                    errors++; $display("FAIL lat_novalid%0d got %b want 0", c, if_valid);
                end
            end
        end
        imem_ack = 1'b0;
        checks++;
        if (imem_addr !== 32'd6 || if_valid !== 1'b1) begin
            errors++; $display("FAIL lat_next got addr=%h v=%b, want 6 1", imem_addr, if_valid);
        end
        sb_drained("latency");
    endtask

    task automatic test_stall();
        goto_pc(32'd8);
        imem_ack = 1'b1;
        stall    = 1'b1;
        sb_expect(32'd8);
        tick_sb();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (if_valid !== 1'b1 || if_pc !== 32'd8 || if_instr !== mem_word(32'd8) || imem_req !== 1'b0) begin
                errors++; $display("FAIL stall_hold%0d got v=%b pc=%h instr=%h req=%b, want 1 8 %h 0",
                                   i, if_valid, if_pc, if_instr, imem_req, mem_word(32'd8));
            end
            if (i == 3) stall = 1'b0;
            tick();
        end
        imem_ack = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd9 || if_valid !== 1'b0) begin
            errors++; $display("FAIL stall_release got req=%b addr=%h v=%b, want 1 9 0", imem_req, imem_addr, if_valid);
        end
        sb_drained("stall");
    endtask

    task automatic test_redirect_wait();
        goto_pc(32'h10);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h10 || if_valid !== 1'b0) begin
            errors++; $display("FAIL redir_outstanding got req=%b addr=%h v=%b, want 1 10 0", imem_req, imem_addr, if_valid);
        end
        tick();
        imem_ack = 1'b1;
        tick_sb();
        checks++;
        if (if_valid !== 1'b0 || imem_addr !== 32'h100) begin
            errors++; $display("FAIL redir_discard got v=%b addr=%h, want 0 100", if_valid, imem_addr);
        end
        sb_expect(32'h100);
        tick_sb();
        imem_ack = 1'b0;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h180;
        tick();
        redirect_pc    = 32'h1C0;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (imem_addr !== 32'h101 || imem_req !== 1'b1) begin
            errors++; $display("FAIL redir_twice_hold got req=%b addr=%h, want 1 101", imem_req, imem_addr);
        end
        imem_ack = 1'b1;
        tick_sb();
        imem_ack = 1'b0;
        checks++;
        if (if_valid !== 1'b0 || imem_addr !== 32'h1C0) begin
            errors++; $display("FAIL redir_twice got v=%b addr=%h, want 0 1c0", if_valid, imem_addr);
        end
        sb_drained("redirect");
    endtask

    task automatic test_exc_priority();
        goto_pc(32'h40);
        imem_ack = 1'b1;
        sb_expect(32'h40);
        tick_sb();
        exc_req        = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        tick_sb();
        exc_req        = 1'b0;
        redirect_valid = 1'b0;
        imem_ack       = 1'b0;
        checks++;
        if (exc_epc !== 32'h40 || imem_addr !== 32'h20 || if_valid !== 1'b0) begin
            errors++; $display("FAIL exc_prio got epc=%h addr=%h v=%b, want 40 20 0", exc_epc, imem_addr, if_valid);
        end
        imem_ack = 1'b1;
        sb_expect(32'h20);
        tick_sb();
        imem_ack = 1'b0;
        tick();
        exc_req = 1'b1;
        tick();
        exc_req = 1'b0;
        checks++;
        if (exc_epc !== 32'h21 || imem_addr !== 32'h21 || imem_req !== 1'b1) begin
            errors++; $display("FAIL exc_wait got epc=%h addr=%h req=%b, want 21 21 1", exc_epc, imem_addr, imem_req);
        end
        imem_ack = 1'b1;
        tick_sb();
        imem_ack = 1'b0;
        checks++;
        if (if_valid !== 1'b0 || imem_addr !== 32'h20) begin
            errors++; $display("FAIL exc_kill got v=%b addr=%h, want 0 20", if_valid, imem_addr);
        end
        sb_drained("exception");
    endtask

    task automatic test_reset_mid_wait();
        goto_pc(32'h55);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'd0 || if_valid !== 1'b0 || if_pc !== 32'd0 || exc_epc !== 32'd0) begin
            errors++; $display("FAIL rstmid_async got req=%b addr=%h v=%b pc=%h epc=%h, want all 0",
                               imem_req, imem_addr, if_valid, if_pc, exc_epc);
        end
        imem_ack = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        tick_sb();
        checks++;
        if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'd0) begin
            errors++; $display("FAIL rstmid_stale got v=%b req=%b addr=%h, want 0 1 0", if_valid, imem_req, imem_addr);
        end
        sb_expect(32'd0);
        tick_sb();
        imem_ack = 1'b0;
        checks++;
        if (imem_addr !== 32'd1) begin
            errors++; $display("FAIL rstmid_resume got addr=%h want 1", imem_addr);
        end
        sb_drained("reset_mid_wait");
    endtask

    task automatic test_wrap();
        rst_n_w = 1'b1;
        tick();
        checks++;
        if (w_imem_req !== 1'b1 || w_imem_addr !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL wrap_first got req=%b addr=%h, want 1 ffffffff", w_imem_req, w_imem_addr);
        end
        imem_ack = 1'b1;
        tick();
        checks++;
        if (w_if_valid !== 1'b1 || w_if_pc !== 32'hFFFF_FFFF || w_if_pc_next !== 32'd0 ||
            w_if_instr !== mem_word(32'hFFFF_FFFF) || w_imem_addr !== 32'd0) begin
            errors++; $display("FAIL wrap_top got v=%b pc=%h nx=%h instr=%h addr=%h, want 1 ffffffff 0 %h 0",
                               w_if_valid, w_if_pc, w_if_pc_next, w_if_instr, w_imem_addr, mem_word(32'hFFFF_FFFF));
        end
        tick();
        imem_ack = 1'b0;
        checks++;
        if (w_if_pc !== 32'd0 || w_if_pc_next !== 32'd1 || w_imem_addr !== 32'd1) begin
            errors++; $display("FAIL wrap_zero got pc=%h nx=%h addr=%h, want 0 1 1", w_if_pc, w_if_pc_next, w_imem_addr);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_latency();
        test_stall();
        test_redirect_wait();
        test_exc_priority();
        test_reset_mid_wait();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
